// File: rtl/frame_buffer_pool_pkg.sv
// Shared types for the frame buffer pool: FSM state, bank index and pixel format.
package frame_buffer_pool_pkg;

    typedef enum logic [1:0] {
        DRAW      = 2'd0,
        WAIT_FLIP = 2'd1,
        CLEARING  = 2'd2
    } fb_state_e;

    typedef logic [1:0] fb_index_t;

    localparam int PIXEL_W = 8;
    typedef logic [PIXEL_W-1:0] pixel_t;

    // With three banks numbered 0..2 the bank that is neither a nor b is 3-a-b.
    function automatic fb_index_t third_bank(input fb_index_t a, input fb_index_t b);
        return fb_index_t'(2'd3 - a - b);
    endfunction

endpackage

// File: rtl/frame_buffer_pool_bank.sv
// One frame bank: registered display read port plus a registered read/write port
// (read-before-write, so a write cycle returns the old pixel).
module frame_bank
    import frame_buffer_pool_pkg::*;
#(
    parameter int ADDR_W = 19
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr,
    output pixel_t            rd_data,
    input  logic [ADDR_W-1:0] rw_addr,
    input  logic              we,
    input  pixel_t            wdata,
    output pixel_t            rw_data
);

    pixel_t mem [2**ADDR_W];

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[rw_addr] <= wdata;
        end
    end

    // Registered read data for both ports, cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
            rw_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
            rw_data <= mem[rw_addr];
        end
    end

endmodule

// File: rtl/frame_buffer_pool.sv
// Double/triple-buffered frame store: the renderer draws into one bank while the
// display scans another; banks flip only on frame_start. Optional clear of each new
// draw bank. Handshake: draw_we and present are accepted only in cycles where
// draw_ready=1; in any other cycle they are dropped with no state change.
module frame_buffer_pool
    import frame_buffer_pool_pkg::*;
#(
    parameter int     ADDR_X_W      = 10,
    parameter int     ADDR_Y_W      = 9,
    parameter int     NUM_BUFFERS   = 2,
    parameter int     CLEAR_ON_SWAP = 0,
    parameter pixel_t CLEAR_VALUE   = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_X_W-1:0] disp_x,
    input  logic [ADDR_Y_W-1:0] disp_y,
    output pixel_t              disp_data,
    input  logic                frame_start,
    input  logic [ADDR_X_W-1:0] draw_x,
    input  logic [ADDR_Y_W-1:0] draw_y,
    input  logic                draw_we,
    input  pixel_t              draw_wdata,
    output pixel_t              draw_rdata,
    output logic                draw_ready,
    input  logic                present,
    output logic                swap_done,
    output fb_index_t           disp_index,
    output fb_index_t           draw_index,
    output fb_state_e           state
);

    localparam int ADDR_W = ADDR_X_W + ADDR_Y_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    if (NUM_BUFFERS != 2 && NUM_BUFFERS != 3) begin : g_bad_num_buffers
        $error("frame_buffer_pool: NUM_BUFFERS must be 2 or 3");
    end

    fb_state_e         state_next;
    fb_index_t         disp_next, draw_next, ready_index, ready_next;
    fb_index_t         disp_sel, draw_sel;
    logic              ready_valid, ready_valid_next, flip;
    logic [ADDR_W-1:0] clear_cnt, clear_next, disp_addr, rw_addr;
    pixel_t            rw_wdata;
    pixel_t            bank_disp [NUM_BUFFERS];
    pixel_t            bank_rw   [NUM_BUFFERS];

    assign draw_ready = (state == DRAW);
    assign disp_addr  = {disp_y, disp_x};
    assign rw_addr    = (state == CLEARING) ? clear_cnt : {draw_y, draw_x};
    assign rw_wdata   = (state == CLEARING) ? CLEAR_VALUE : draw_wdata;

    // Next-state: bank rotation, flips, FSM transitions and the clear sweep.
    always_comb begin
        state_next       = state;
        disp_next        = disp_index;
        draw_next        = draw_index;
        ready_next       = ready_index;
        ready_valid_next = ready_valid;
        clear_next       = clear_cnt;
        flip             = 1'b0;
        if (NUM_BUFFERS == 3) begin
            // The flip consumes the ready slot as it stood before this cycle's present.
            if (frame_start && ready_valid) begin
                flip             = 1'b1;
                disp_next        = ready_index;
                ready_valid_next = 1'b0;
            end
            if (present && draw_ready) begin
                ready_next       = draw_index;
                ready_valid_next = 1'b1;
                draw_next        = third_bank(disp_next, draw_index);
                if (CLEAR_ON_SWAP != 0) begin
                    state_next = CLEARING;
                end
            end
        end else begin
            case (state)
                DRAW: begin
                    if (present) begin
                        state_next = WAIT_FLIP;
                    end
                end
                WAIT_FLIP: begin
                    if (frame_start) begin
                        flip       = 1'b1;
                        disp_next  = draw_index;
                        draw_next  = disp_index;
                        state_next = (CLEAR_ON_SWAP != 0) ? CLEARING : DRAW;
                    end
                end
                default: ;
            endcase
        end
        if (state == CLEARING) begin
            if (clear_cnt == LAST_ADDR) begin
                clear_next = '0;
                state_next = DRAW;
            end else begin
                clear_next = clear_cnt + ADDR_W'(1);
            end
        end
    end

    // State and index registers; read-mux selects follow the indices at the read edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= DRAW;
            disp_index  <= 2'd0;
            draw_index  <= 2'd1;
            ready_index <= 2'd2;
            ready_valid <= 1'b0;
            clear_cnt   <= '0;
            swap_done   <= 1'b0;
            disp_sel    <= 2'd0;
            draw_sel    <= 2'd1;
        end else begin
            state       <= state_next;
            disp_index  <= disp_next;
            draw_index  <= draw_next;
            ready_index <= ready_next;
            ready_valid <= ready_valid_next;
            clear_cnt   <= clear_next;
            swap_done   <= flip;
            disp_sel    <= disp_index;
            draw_sel    <= draw_index;
        end
    end

    for (genvar i = 0; i < NUM_BUFFERS; i++) begin : g_bank
        logic we;
        assign we = (draw_index == fb_index_t'(i)) &&
                    ((state == CLEARING) || (draw_we && draw_ready));
        frame_bank #(.ADDR_W(ADDR_W)) u_bank (
            .clock   (clock),
            .reset   (reset),
            .rd_addr (disp_addr),
            .rd_data (bank_disp[i]),
            .rw_addr (rw_addr),
            .we      (we),
            .wdata   (rw_wdata),
            .rw_data (bank_rw[i])
        );
    end

    // Output muxes pick the bank that was selected when the read was issued.
    always_comb begin
        disp_data  = '0;
        draw_rdata = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (disp_sel == fb_index_t'(i)) disp_data  = bank_disp[i];
            if (draw_sel == fb_index_t'(i)) draw_rdata = bank_rw[i];
        end
    end

endmodule

// File: tb/tb_frame_buffer_pool.sv
// Bench for frame_buffer_pool: three instances (double, triple, double+clear) driven
// every cycle; a reference model of bank contents and frame hand-off predicts outputs.
module tb_frame_buffer_pool;
    import frame_buffer_pool_pkg::*;

    localparam int     XW    = 4;
    localparam int     YW    = 3;
    localparam int     DEPTH = 128;
    localparam pixel_t CLR   = 8'hA5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          rst_s [3];
    logic          pres_s [3], fs_s [3], we_s [3];
    logic [XW-1:0] dx_s [3], ddx_s [3];
    logic [YW-1:0] dy_s [3], ddy_s [3];
    pixel_t        wd_s [3], dd_o [3], rd_o [3];
    logic          rdy_o [3], sw_o [3];
    logic [1:0]    di_o [3], wi_o [3];
    fb_state_e     st_o [3];

    frame_buffer_pool #(.ADDR_X_W(XW), .ADDR_Y_W(YW), .NUM_BUFFERS(2), .CLEAR_ON_SWAP(0), .CLEAR_VALUE(CLR)) u_nb2 (
        .clock(clock), .reset(rst_s[0]), .disp_x(ddx_s[0]), .disp_y(ddy_s[0]), .disp_data(dd_o[0]),
        .frame_start(fs_s[0]), .draw_x(dx_s[0]), .draw_y(dy_s[0]), .draw_we(we_s[0]), .draw_wdata(wd_s[0]),
        .draw_rdata(rd_o[0]), .draw_ready(rdy_o[0]), .present(pres_s[0]), .swap_done(sw_o[0]),
        .disp_index(di_o[0]), .draw_index(wi_o[0]), .state(st_o[0]));

    frame_buffer_pool #(.ADDR_X_W(XW), .ADDR_Y_W(YW), .NUM_BUFFERS(3), .CLEAR_ON_SWAP(0), .CLEAR_VALUE(CLR)) u_nb3 (
        .clock(clock), .reset(rst_s[1]), .disp_x(ddx_s[1]), .disp_y(ddy_s[1]), .disp_data(dd_o[1]),
        .frame_start(fs_s[1]), .draw_x(dx_s[1]), .draw_y(dy_s[1]), .draw_we(we_s[1]), .draw_wdata(wd_s[1]),
        .draw_rdata(rd_o[1]), .draw_ready(rdy_o[1]), .present(pres_s[1]), .swap_done(sw_o[1]),
        .disp_index(di_o[1]), .draw_index(wi_o[1]), .state(st_o[1]));

    frame_buffer_pool #(.ADDR_X_W(XW), .ADDR_Y_W(YW), .NUM_BUFFERS(2), .CLEAR_ON_SWAP(1), .CLEAR_VALUE(CLR)) u_clr (
        .clock(clock), .reset(rst_s[2]), .disp_x(ddx_s[2]), .disp_y(ddy_s[2]), .disp_data(dd_o[2]),
        .frame_start(fs_s[2]), .draw_x(dx_s[2]), .draw_y(dy_s[2]), .draw_we(we_s[2]), .draw_wdata(wd_s[2]),
        .draw_rdata(rd_o[2]), .draw_ready(rdy_o[2]), .present(pres_s[2]), .swap_done(sw_o[2]),
        .disp_index(di_o[2]), .draw_index(wi_o[2]), .state(st_o[2]));

    typedef struct {
        int         k;
        logic [1:0] di, wi;
        logic       rdy, sw;
        pixel_t     dd, rd;
        bit         dd_ok, rd_ok;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: per-instance bank images, which bank is shown / drawn,
    // frames waiting for display, and how many clear writes are still owed.
    pixel_t mem_m   [3][3][DEPTH];
    bit     known_m [3][3][DEPTH];
    int     m_disp [3], m_draw [3], m_clear_left [3];
    bit     m_wait [3];
    int     pend_q [$];

    // Per-cycle stimulus requests (pulses are cleared after each cycle).
    bit     p_in [3], fs_in [3], we_in [3], rst_req [3], rel_req [3];
    int     wa_in [3], da_in [3];
    pixel_t wd_in [3];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    task automatic check_item(input exp_t e);
        chk("disp_index", e.k, 32'(di_o[e.k]), 32'(e.di));
        chk("draw_index", e.k, 32'(wi_o[e.k]), 32'(e.wi));
        chk("draw_ready", e.k, 32'(rdy_o[e.k]), 32'(e.rdy));
        chk("swap_done", e.k, 32'(sw_o[e.k]), 32'(e.sw));
        if (e.dd_ok) chk("disp_data", e.k, 32'(dd_o[e.k]), 32'(e.dd));
        if (e.rd_ok) chk("draw_rdata", e.k, 32'(rd_o[e.k]), 32'(e.rd));
    endtask

    function automatic exp_t reset_item(input int k);
        exp_t e;
        e.k = k; e.di = 2'd0; e.wi = 2'd1; e.rdy = 1'b1; e.sw = 1'b0;
        e.dd = '0; e.rd = '0; e.dd_ok = 1'b1; e.rd_ok = 1'b1;
        return e;
    endfunction

    task automatic model_reset(input int k);
        m_disp[k] = 0; m_draw[k] = 1; m_wait[k] = 1'b0; m_clear_left[k] = 0;
        if (k == 1) pend_q.delete();
    endtask

    // Advance the model by one clock for instance k and return what it should show afterwards.
    task automatic step_model(input int k, output exp_t e);
        bit writable;
        int a, t;
        if (rst_s[k] == 1'b0) begin
            e = reset_item(k);
            return;
        end
        e.k     = k;
        e.sw    = 1'b0;
        e.dd    = mem_m[k][m_disp[k]][da_in[k]];
        e.dd_ok = known_m[k][m_disp[k]][da_in[k]];
        e.rd    = mem_m[k][m_draw[k]][wa_in[k]];
        e.rd_ok = known_m[k][m_draw[k]][wa_in[k]] && (m_clear_left[k] == 0);
        writable = !m_wait[k] && (m_clear_left[k] == 0);
        if (m_clear_left[k] > 0) begin
            a = DEPTH - m_clear_left[k];
            mem_m[k][m_draw[k]][a]   = CLR;
            known_m[k][m_draw[k]][a] = 1'b1;
            m_clear_left[k]--;
        end else if (we_in[k] && writable) begin
            mem_m[k][m_draw[k]][wa_in[k]]   = wd_in[k];
            known_m[k][m_draw[k]][wa_in[k]] = 1'b1;
        end
        if (k == 1) begin
            if (fs_in[k] && pend_q.size() > 0) begin
                m_disp[k] = pend_q.pop_front();
                e.sw = 1'b1;
            end
            if (p_in[k] && writable) begin
                pend_q.push_back(m_draw[k]);
                if (pend_q.size() > 1) begin
                    m_draw[k] = pend_q.pop_front();
                end else begin
                    for (int b = 0; b < 3; b++)
                        if (b != m_disp[k] && b != pend_q[0]) m_draw[k] = b;
                end
            end
        end else begin
            if (m_wait[k] && fs_in[k]) begin
                t = m_disp[k]; m_disp[k] = m_draw[k]; m_draw[k] = t;
                m_wait[k] = 1'b0;
                e.sw = 1'b1;
                if (k == 2) m_clear_left[k] = DEPTH;
            end else if (p_in[k] && writable) begin
                m_wait[k] = 1'b1;
            end
        end
        e.di  = 2'(m_disp[k]);
        e.wi  = 2'(m_draw[k]);
        e.rdy = !m_wait[k] && (m_clear_left[k] == 0);
    endtask

    // One clock of stimulus for all instances: drive at negedge, predict, push expectations.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            if (rst_req[k]) rst_s[k] = 1'b0;
            if (rel_req[k]) rst_s[k] = 1'b1;
            pres_s[k] = p_in[k]; fs_s[k] = fs_in[k]; we_s[k] = we_in[k];
            dx_s[k]  = XW'(wa_in[k] % 16); dy_s[k]  = YW'(wa_in[k] / 16);
            ddx_s[k] = XW'(da_in[k] % 16); ddy_s[k] = YW'(da_in[k] / 16);
            wd_s[k]  = wd_in[k];
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            if (rst_req[k]) begin
                check_item(reset_item(k));
                model_reset(k);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step_model(k, e);
            exp_q.push_back(e);
            p_in[k] = 1'b0; fs_in[k] = 1'b0; we_in[k] = 1'b0; rst_req[k] = 1'b0; rel_req[k] = 1'b0;
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            pres_s[k] = 1'b0; fs_s[k] = 1'b0; we_s[k] = 1'b0;
        end
    endtask

    task automatic rnd(input int k, input int p_pct, input int fs_pct, input int we_pct);
        p_in[k]  = ($urandom_range(0, 99) < p_pct);
        fs_in[k] = ($urandom_range(0, 99) < fs_pct);
        we_in[k] = ($urandom_range(0, 99) < we_pct);
        wa_in[k] = $urandom_range(0, DEPTH - 1);
        da_in[k] = $urandom_range(0, DEPTH - 1);
        wd_in[k] = pixel_t'($urandom);
    endtask

    // Monitor: two time units after each active edge, compare outputs with queued expectations.
    initial begin
        int n;
        forever begin
            @(posedge clock);
            #2;
            n = 0;
            while (exp_q.size() > 0 && n < 3) begin
                check_item(exp_q.pop_front());
                n++;
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_s[k] = 1'b0; pres_s[k] = 1'b0; fs_s[k] = 1'b0; we_s[k] = 1'b0;
            dx_s[k] = '0; dy_s[k] = '0; ddx_s[k] = '0; ddy_s[k] = '0; wd_s[k] = '0;
            p_in[k] = 1'b0; fs_in[k] = 1'b0; we_in[k] = 1'b0; rst_req[k] = 1'b0; rel_req[k] = 1'b0;
            wa_in[k] = 0; da_in[k] = 0; wd_in[k] = '0;
            model_reset(k);
        end
        repeat (2) tick();
        for (int k = 0; k < 3; k++) rel_req[k] = 1'b1;
        tick();

        // Drawing with stray frame_starts and no presents: nothing flips.
        for (int c = 0; c < 60; c++) begin
            for (int k = 0; k < 3; k++) rnd(k, 0, 10, 70);
            if (c == 59) for (int k = 0; k < 3; k++) begin
                we_in[k] = 1'b1; wa_in[k] = 7 * 16 + 3; wd_in[k] = 8'h37;
            end
            tick();
        end

        // Present, blocked writes on the double buffer, second present on the triple buffer,
        // frame_start five cycles later, then sweep the displayed frames.
        p_in[0] = 1'b1; p_in[1] = 1'b1; tick();
        for (int c = 0; c < 4; c++) begin
            rnd(0, 0, 0, 80); rnd(1, 0, 0, 80);
            if (c == 1) p_in[1] = 1'b1;
            tick();
        end
        fs_in[0] = 1'b1; fs_in[1] = 1'b1; tick();
        for (int a = 0; a < DEPTH; a++) begin
            da_in[0] = (a + 115) % DEPTH; da_in[1] = (a + 115) % DEPTH;
            rnd(1, 0, 0, 50);
            tick();
        end

        // Same-cycle present and frame_start on the double buffer.
        p_in[0] = 1'b1; fs_in[0] = 1'b1; tick();
        for (int c = 0; c < 3; c++) begin rnd(0, 0, 0, 60); tick(); end
        fs_in[0] = 1'b1; tick();
        repeat (3) tick();

        // Clear after flip, presents during the clear, then read back the whole draw bank.
        p_in[2] = 1'b1; tick();
        repeat (2) tick();
        fs_in[2] = 1'b1; tick();
        for (int c = 0; c < DEPTH; c++) begin rnd(2, 10, 10, 50); tick(); end
        for (int a = 0; a < DEPTH; a++) begin
            wa_in[2] = a; da_in[2] = $urandom_range(0, DEPTH - 1); tick();
        end

        // Reset forty cycles into a clear, then resume.
        p_in[2] = 1'b1; tick();
        fs_in[2] = 1'b1; tick();
        repeat (40) tick();
        rst_req[2] = 1'b1; tick();
        tick();
        rel_req[2] = 1'b1; tick();

        // Free-running random traffic on all instances.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) rnd(k, 8, 12, 60);
            tick();
        end

        repeat (3) @(posedge clock);
        #3;
        chk("queue_drained", 0, 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
